// File: rtl/nbody_pkg.sv
// Shared definitions for the n-body register interface.
// Holds bus select codes, body field encodings, FSM states and address width.
package nbody_pkg;

   localparam int unsigned BODY_ADDR_WIDTH = 9;
   localparam int unsigned DataWidth       = 64;

   // Write selects
   localparam logic [6:0] SelGo      = 7'h00;
   localparam logic [6:0] SelRead    = 7'h01;
   localparam logic [6:0] SelNBodies = 7'h02;
   localparam logic [6:0] SelX       = 7'h03;
   localparam logic [6:0] SelY       = 7'h04;
   localparam logic [6:0] SelM       = 7'h05;
   localparam logic [6:0] SelVx      = 7'h06;
   localparam logic [6:0] SelVy      = 7'h07;
   localparam logic [6:0] SelGap     = 7'h08;

   // Read selects
   localparam logic [6:0] SelDone    = 7'h40;
   localparam logic [6:0] SelReadX   = 7'h41;
   localparam logic [6:0] SelReadY   = 7'h42;
   localparam logic [6:0] SelErrCnt  = 7'h43;

   typedef enum logic [2:0] {
      FieldX  = 3'd0,
      FieldY  = 3'd1,
      FieldM  = 3'd2,
      FieldVx = 3'd3,
      FieldVy = 3'd4
   } field_e;

   typedef enum logic [1:0] {
      StIdle = 2'd0,
      StRun  = 2'd1,
      StDone = 2'd2
   } state_e;

   function automatic field_e sel_to_field(input logic [6:0] sel);
      case (sel)
         SelY:    return FieldY;
         SelM:    return FieldM;
         SelVx:   return FieldVx;
         SelVy:   return FieldVy;
         default: return FieldX;
      endcase
   endfunction

endpackage

// File: rtl/nbody_rd_pipe.sv
// Two-stage read-return pipeline: stage 1 issues the core read, stage 2 lands readdata.
// Each slot carries a valid bit, a core/immediate tag and the immediate value.
module nbody_rd_pipe
   import nbody_pkg::*;
#(
   parameter int unsigned IdxWidth = 9
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 req_valid,
   input  logic                 req_core,
   input  logic                 req_sel,
   input  logic [IdxWidth-1:0]  req_idx,
   input  logic [DataWidth-1:0] req_imm,
   output logic                 rd_en,
   output logic                 rd_sel,
   output logic [IdxWidth-1:0]  rd_idx,
   input  logic [DataWidth-1:0] rd_data,
   output logic [DataWidth-1:0] readdata
);

   logic                 s1_valid_q;
   logic                 s1_core_q;
   logic                 s1_sel_q;
   logic [IdxWidth-1:0]  s1_idx_q;
   logic [DataWidth-1:0] s1_imm_q;
   logic                 s2_valid_q;
   logic                 s2_core_q;
   logic [DataWidth-1:0] s2_imm_q;
   logic [DataWidth-1:0] readdata_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         s1_valid_q <= 1'b0;
         s1_core_q  <= 1'b0;
         s1_sel_q   <= 1'b0;
         s1_idx_q   <= '0;
         s1_imm_q   <= '0;
         s2_valid_q <= 1'b0;
         s2_core_q  <= 1'b0;
         s2_imm_q   <= '0;
         readdata_q <= '0;
      end else begin
         s1_valid_q <= req_valid;
         s1_core_q  <= req_valid & req_core;
         s1_sel_q   <= req_sel;
         s1_idx_q   <= req_idx;
         s1_imm_q   <= req_imm;
         s2_valid_q <= s1_valid_q;
         s2_core_q  <= s1_core_q;
         s2_imm_q   <= s1_imm_q;
         // Core data arrives one cycle after rd_en, aligned with stage 2.
         if (s2_valid_q) begin
            readdata_q <= s2_core_q ? rd_data : s2_imm_q;
         end
      end
   end

   assign rd_en    = s1_valid_q & s1_core_q;
   assign rd_sel   = s1_sel_q;
   assign rd_idx   = s1_idx_q;
   assign readdata = readdata_q;

endmodule

// File: rtl/nbody_regif.sv
// Avalon-MM register interface for the n-body core: body writes, run control, position reads.
// Define NBODY_REGIF_ERRCNT_EN to add a dropped-write counter readable at select 0x43.
module nbody_regif #(
   parameter int unsigned BODY_ADDR_WIDTH = nbody_pkg::BODY_ADDR_WIDTH,
   parameter int unsigned MAX_BODIES      = 512
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       chipselect,
   input  logic                       read,
   input  logic                       write,
   input  logic [15:0]                addr,
   input  logic [63:0]                writedata,
   output logic [63:0]                readdata,
   output logic                       wr_en,
   output logic [2:0]                 wr_field,
   output logic [BODY_ADDR_WIDTH-1:0] wr_idx,
   output logic [63:0]                wr_data,
   output logic                       rd_en,
   output logic                       rd_sel,
   output logic [BODY_ADDR_WIDTH-1:0] rd_idx,
   input  logic [63:0]                rd_data,
   output logic [BODY_ADDR_WIDTH:0]   n_bodies,
   output logic [31:0]                gap,
   output logic                       core_start,
   output logic                       core_freeze,
   input  logic                       core_done
);

   import nbody_pkg::*;

   localparam int unsigned NbW = BODY_ADDR_WIDTH + 1;

   logic [6:0]                 sel;
   logic [BODY_ADDR_WIDTH-1:0] idx;
   logic                       wr_acc;
   logic                       rd_acc;
   logic                       in_run;
   logic                       idx_ok;
   logic                       is_field;
   logic                       field_acc;
   logic                       go_wr;
   logic [NbW-1:0]             nb_sat;

   state_e                     state_q, state_d;
   logic                       start_q, start_d;
   logic                       wr_en_q;
   logic [2:0]                 wr_field_q;
   logic [BODY_ADDR_WIDTH-1:0] wr_idx_q;
   logic [63:0]                wr_data_q;
   logic [NbW-1:0]             n_bodies_q;
   logic [31:0]                gap_q;
   logic                       freeze_q;

   logic                       req_core;
   logic                       req_sel;
   logic [63:0]                req_imm;

   assign sel    = addr[15:9];
   assign idx    = addr[BODY_ADDR_WIDTH-1:0];
   // Write has priority over a simultaneous read.
   assign wr_acc = chipselect & write;
   assign rd_acc = chipselect & read & ~write;
   assign in_run = (state_q == StRun);
   assign go_wr  = wr_acc && (sel == SelGo);

   if (MAX_BODIES >= (1 << BODY_ADDR_WIDTH)) begin : g_idx_full
      assign idx_ok = 1'b1;
   end else begin : g_idx_lim
      assign idx_ok = (32'(idx) < MAX_BODIES);
   end

   assign is_field  = wr_acc && (sel >= SelX) && (sel <= SelVy);
   assign field_acc = is_field && idx_ok && !in_run;
   assign nb_sat    = (writedata > 64'(MAX_BODIES)) ? NbW'(MAX_BODIES) : writedata[NbW-1:0];

   always_comb begin
      state_d = state_q;
      start_d = 1'b0;
      unique case (state_q)
         StIdle: begin
            if (go_wr && writedata[0] && (n_bodies_q != '0)) begin
               state_d = StRun;
               start_d = 1'b1;
            end
         end
         StRun: begin
            if (core_done) begin
               state_d = StDone;
            end
         end
         StDone: begin
         end
         default: state_d = StIdle;
      endcase
      // GO=0 aborts from any state and overrides a coincident core_done.
      if (go_wr && !writedata[0]) begin
         state_d = StIdle;
         start_d = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= StIdle;
         start_q    <= 1'b0;
         wr_en_q    <= 1'b0;
         wr_field_q <= '0;
         wr_idx_q   <= '0;
         wr_data_q  <= '0;
         n_bodies_q <= '0;
         gap_q      <= '0;
         freeze_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         start_q <= start_d;
         wr_en_q <= field_acc;
         if (field_acc) begin
            wr_field_q <= sel_to_field(sel);
            wr_idx_q   <= idx;
            wr_data_q  <= writedata;
         end
         if (wr_acc && (sel == SelNBodies) && !in_run) begin
            n_bodies_q <= nb_sat;
         end
         if (wr_acc && (sel == SelGap) && !in_run) begin
            gap_q <= writedata[31:0];
         end
         if (wr_acc && (sel == SelRead)) begin
            freeze_q <= writedata[0];
         end
      end
   end

`ifdef NBODY_REGIF_ERRCNT_EN
   logic        drop;
   logic [15:0] errcnt_q;

   assign drop = (is_field && !field_acc) ||
                 (wr_acc && in_run && ((sel == SelNBodies) || (sel == SelGap)));

   always_ff @(posedge clk) begin
      if (rst) begin
         errcnt_q <= '0;
      end else if (wr_acc && (sel == SelErrCnt)) begin
         errcnt_q <= '0;
      end else if (drop && (errcnt_q != 16'hffff)) begin
         errcnt_q <= errcnt_q + 16'd1;
      end
   end
`endif

   // Position reads go to the core unless it is running unfrozen; everything else is immediate.
   always_comb begin
      req_core = 1'b0;
      req_sel  = 1'b0;
      req_imm  = '0;
      case (sel)
         SelReadX, SelReadY: begin
            req_sel  = (sel == SelReadY);
            req_core = !in_run || freeze_q;
         end
         SelDone: req_imm = {63'b0, state_q == StDone};
`ifdef NBODY_REGIF_ERRCNT_EN
         SelErrCnt: req_imm = {48'b0, errcnt_q};
`endif
         default: begin
         end
      endcase
   end

   nbody_rd_pipe #(
      .IdxWidth (BODY_ADDR_WIDTH)
   ) u_rd_pipe (
      .clk       (clk),
      .rst       (rst),
      .req_valid (rd_acc),
      .req_core  (req_core),
      .req_sel   (req_sel),
      .req_idx   (idx),
      .req_imm   (req_imm),
      .rd_en     (rd_en),
      .rd_sel    (rd_sel),
      .rd_idx    (rd_idx),
      .rd_data   (rd_data),
      .readdata  (readdata)
   );

   assign wr_en       = wr_en_q;
   assign wr_field    = wr_field_q;
   assign wr_idx      = wr_idx_q;
   assign wr_data     = wr_data_q;
   assign n_bodies    = n_bodies_q;
   assign gap         = gap_q;
   assign core_start  = start_q;
   assign core_freeze = freeze_q;

endmodule
